// File: rtl/nes_multi_pad_reader.sv
// nes_multi_pad_reader
//   Polls NUM_PADS serial game pads (NES 8-bit or SNES 16-bit) over one shared
//   latch (srl_o) and shift clock (srclk_o), each pad having its own serial
//   data line. A poll starts automatically at every frame-counter wrap while
//   en_i is high. All pads are published together in one cycle, with a valid
//   strobe and per-button press-edge pulses.
//
// Ports
//   clk_i      system clock
//   reset_i    synchronous reset, active low
//   en_i       1 = allow new polls (a poll in progress always completes)
//   sdata_i    per-pad serial data, active low, asynchronous
//   srl_o      shared latch, registered
//   srclk_o    shared shift clock, registered
//   buttons_o  pad p bit i at [p*NUM_BITS+i], 1 = pressed
//              (bit0 A, 1 B, 2 SEL, 3 STRT, 4 UP, 5 DN, 6 L, 7 R)
//   pressed_o  one-cycle pulse per button on its 0->1 transition
//   valid_o    one-cycle pulse in the cycle buttons_o takes a new value
//   busy_o     high while a poll is in progress
//
// state  | meaning
// IDLE   | waiting for frame counter == 0 with en_i high
// LATCH  | srl high for LATCH_CYC cycles
// LOW    | srclk low for CLK_DIV cycles, sample bit on the last cycle
// HIGH   | srclk high for CLK_DIV cycles (absent after the last bit)
// DONE   | one cycle, publish shadow to buttons/pressed/valid

module nes_multi_pad_reader #(
  parameter int NUM_PADS  = 2,
  parameter int NUM_BITS  = 8,
  parameter int LATCH_CYC = 600,
  parameter int CLK_DIV   = 300,
  parameter int POLL_CYC  = 833333
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic [NUM_PADS-1:0]          sdata_i,
  output logic                         srl_o,
  output logic                         srclk_o,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons_o,
  output logic [NUM_PADS*NUM_BITS-1:0] pressed_o,
  output logic                         valid_o,
  output logic                         busy_o
);

  localparam int VW      = NUM_PADS * NUM_BITS;
  localparam int TMAX    = (LATCH_CYC > CLK_DIV) ? LATCH_CYC : CLK_DIV;
  localparam int TW      = $clog2(TMAX);
  localparam int BW      = $clog2(NUM_BITS);
  localparam int FW      = $clog2(POLL_CYC);
  localparam int LATENCY = LATCH_CYC + (2 * NUM_BITS - 1) * CLK_DIV + 1;

  // A poll must finish before the next frame wrap, otherwise a start would be missed.
  generate
    if (LATENCY >= POLL_CYC) begin : g_latency_check
      $error("nes_multi_pad_reader: poll latency %0d not below POLL_CYC %0d", LATENCY, POLL_CYC);
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [VW-1:0]         shadow_q, shadow_d;
  logic [VW-1:0]         shadow_shift;
  logic [FW-1:0]         frame_q;
  logic [NUM_PADS-1:0]   sync1_q, sync2_q;
  logic                  srl_q, srclk_q, busy_q, valid_q;
  logic [VW-1:0]         buttons_q, pressed_q;

  // Bits arrive A first; shifting in at the MSB leaves bit 0 at the LSB
  // once all NUM_BITS samples have been taken.
  generate
    for (genvar gp = 0; gp < NUM_PADS; gp++) begin : g_pad
      assign shadow_shift[gp*NUM_BITS +: NUM_BITS] =
        {~sync2_q[gp], shadow_q[gp*NUM_BITS+1 +: NUM_BITS-1]};
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    shadow_d = shadow_q;
    unique case (state_q)
      S_IDLE: begin
        if (en_i && (frame_q == '0)) begin
          state_d = S_LATCH;
          timer_d = TW'(LATCH_CYC - 1);
        end
      end
      S_LATCH: begin
        if (timer_q == '0) begin
          state_d = S_LOW;
          timer_d = TW'(CLK_DIV - 1);
          bit_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_LOW: begin
        if (timer_q == '0) begin
          shadow_d = shadow_shift;
          timer_d  = TW'(CLK_DIV - 1);
          if (bit_q == BW'(NUM_BITS - 1)) state_d = S_DONE;
          else                            state_d = S_HIGH;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (timer_q == '0) begin
          state_d = S_LOW;
          timer_d = TW'(CLK_DIV - 1);
          bit_d   = bit_q + 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_q     <= '0;
      shadow_q  <= '0;
      frame_q   <= '0;
      sync1_q   <= '1;
      sync2_q   <= '1;
      srl_q     <= 1'b0;
      srclk_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      buttons_q <= '0;
      pressed_q <= '0;
    end else begin
      sync1_q  <= sdata_i;
      sync2_q  <= sync1_q;
      frame_q  <= (frame_q == FW'(POLL_CYC - 1)) ? '0 : frame_q + 1'b1;
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      shadow_q <= shadow_d;
      // Outputs decoded from the next state so they line up with the state itself.
      srl_q    <= (state_d == S_LATCH);
      srclk_q  <= (state_d == S_HIGH);
      busy_q   <= (state_d == S_LATCH) || (state_d == S_LOW) || (state_d == S_HIGH);
      valid_q  <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        buttons_q <= shadow_q;
        pressed_q <= shadow_q & ~buttons_q;
      end else begin
        pressed_q <= '0;
      end
    end
  end

  assign srl_o     = srl_q;
  assign srclk_o   = srclk_q;
  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign buttons_o = buttons_q;
  assign pressed_o = pressed_q;

endmodule

// File: tb/tb_nes_multi_pad_reader.sv
module tb_nes_multi_pad_reader;

  localparam int NP  = 2;
  localparam int NB  = 8;
  localparam int LC  = 4;
  localparam int CD  = 3;
  localparam int PC  = 64;
  localparam int LAT = LC + (2 * NB - 1) * CD + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_b, en;
  logic [NP-1:0]      sdata;
  logic               srl, srclk, valid, busy;
  logic [NP*NB-1:0]   buttons, pressed;

  logic               en16;
  logic [0:0]         sdata16;
  logic               srl16, srclk16, valid16, busy16;
  logic [15:0]        buttons16, pressed16;

  nes_multi_pad_reader #(
    .NUM_PADS(NP), .NUM_BITS(NB), .LATCH_CYC(LC), .CLK_DIV(CD), .POLL_CYC(PC)
  ) u_dut (
    .clk_i(clk), .reset_i(rst_b), .en_i(en), .sdata_i(sdata),
    .srl_o(srl), .srclk_o(srclk), .buttons_o(buttons), .pressed_o(pressed),
    .valid_o(valid), .busy_o(busy)
  );

  nes_multi_pad_reader #(
    .NUM_PADS(1), .NUM_BITS(16), .LATCH_CYC(LC), .CLK_DIV(CD), .POLL_CYC(128)
  ) u_dut16 (
    .clk_i(clk), .reset_i(rst_b), .en_i(en16), .sdata_i(sdata16),
    .srl_o(srl16), .srclk_o(srclk16), .buttons_o(buttons16), .pressed_o(pressed16),
    .valid_o(valid16), .busy_o(busy16)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pad models: parallel load while srl is high, shift on srclk rising, active-low data.
  logic [NB-1:0] pad_val [NP];
  logic [15:0]   pad16;
  bit            noise;

  initial begin
    int idx = 0;
    int idx16 = 0;
    bit prev = 1'b0;
    bit prev16 = 1'b0;
    logic [NB-1:0] tmp;
    logic [15:0] tmp16;
    logic [NP-1:0] v;
    sdata = '1;
    sdata16 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (srl) idx = 0;
      else if (srclk && !prev) idx++;
      prev = srclk;
      if (srl16) idx16 = 0;
      else if (srclk16 && !prev16) idx16++;
      prev16 = srclk16;
      for (int p = 0; p < NP; p++) begin
        tmp = pad_val[p] >> idx;
        if (noise)        v[p] = 1'($urandom_range(1));
        else if (idx < NB) v[p] = ~tmp[0];
        else              v[p] = 1'b0;
      end
      sdata = v;
      tmp16 = pad16 >> idx16;
      sdata16 = (idx16 < 16) ? ~tmp16[0] : 1'b0;
    end
  end

  // Behavioural model: poll phase k counts edges since the start edge.
  int          m_frame = 0;
  int          m_k = -1;
  logic [15:0] m_btn = '0, m_press = '0, m_next;
  bit          m_valid = 1'b0, m_live = 1'b0;

  always @(posedge clk) begin
    m_live  = 1'b1;
    m_valid = 1'b0;
    m_press = '0;
    if (!rst_b) begin
      m_frame = 0;
      m_k     = -1;
      m_btn   = '0;
    end else begin
      if (m_k >= 0) begin
        m_k++;
        if (m_k == LAT + 1) begin
          m_next  = {pad_val[1], pad_val[0]};
          m_press = m_next & ~m_btn;
          m_btn   = m_next;
          m_valid = 1'b1;
          m_k     = -1;
        end
      end else if (m_frame == 0 && en) begin
        m_k = 1;
      end
      m_frame = (m_frame + 1) % PC;
    end
  end

  function automatic bit exp_srl();
    return (m_k >= 1) && (m_k <= LC);
  endfunction

  function automatic bit exp_srclk();
    int j;
    j = m_k - (LC + 1);
    return (m_k > LC) && (j < (2 * NB - 1) * CD) && ((j % (2 * CD)) >= CD);
  endfunction

  function automatic bit exp_busy();
    return (m_k >= 1) && (m_k <= LAT - 1);
  endfunction

  always @(negedge clk) begin
    if (m_live) begin
      check("srl",     32'(srl),     32'(exp_srl()));
      check("srclk",   32'(srclk),   32'(exp_srclk()));
      check("busy",    32'(busy),    32'(exp_busy()));
      check("valid",   32'(valid),   32'(m_valid));
      check("buttons", 32'(buttons), 32'(m_btn));
      check("pressed", 32'(pressed), 32'(m_press));
    end
  end

  // Observers for poll shape: latency from first srl cycle to valid, srclk pulse count.
  int cyc = 0, srl_start = 0, pulses = 0, srl_rises = 0, last_lat = 0, last_pulses = 0;
  int s16_start = 0, pulses16 = 0, lat16 = 0, last_pulses16 = 0;
  bit srl_p = 1'b0, srclk_p = 1'b0, srl16_p = 1'b0, srclk16_p = 1'b0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (srl && !srl_p) begin srl_start = cyc; pulses = 0; srl_rises++; end
    if (srclk && !srclk_p) pulses++;
    if (valid) begin last_lat = cyc - srl_start; last_pulses = pulses; end
    srl_p = srl; srclk_p = srclk;
    if (srl16 && !srl16_p) begin s16_start = cyc; pulses16 = 0; end
    if (srclk16 && !srclk16_p) pulses16++;
    if (valid16) begin lat16 = cyc - s16_start; last_pulses16 = pulses16; end
    srl16_p = srl16; srclk16_p = srclk16;
  end

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < budget);
    check({name, "_valid_seen"}, 32'(valid), 32'd1);
  endtask

  task automatic wait_srl(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!srl && n < budget);
    check({name, "_srl_seen"}, 32'(srl), 32'd1);
  endtask

  initial begin
    int n;
    int snap;
    rst_b = 1'b0; en = 1'b0; en16 = 1'b1; noise = 1'b1;
    pad_val[0] = 8'hA5; pad_val[1] = 8'h3C; pad16 = 16'h8001;

    // 1: reset with noisy pads
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_buttons", 32'(buttons), 32'h0);
    check("rst_srl",     32'(srl),     32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1; en = 1'b1; noise = 1'b0;

    // 2: first poll
    wait_valid("t2", 100);
    check("t2_buttons", 32'(buttons), 32'h3CA5);
    check("t2_pressed", 32'(pressed), 32'h3CA5);
    check("t2_latency", 32'(last_lat), 32'd50);
    check("t2_pulses",  32'(last_pulses), 32'd7);
    @(negedge clk);
    check("t2_pressed_gone", 32'(pressed), 32'h0);

    // 3: one new button
    @(posedge clk); #1;
    pad_val[0] = 8'hA7;
    wait_valid("t3", 100);
    check("t3_buttons", 32'(buttons), 32'h3CA7);
    check("t3_pressed", 32'(pressed), 32'h0002);
    @(negedge clk);
    check("t3_pressed_gone", 32'(pressed), 32'h0);

    // 4: en dropped mid-poll, raised mid-frame
    wait_srl("t4", 100);
    repeat (19) @(posedge clk);
    #1 en = 1'b0;
    wait_valid("t4", 100);
    check("t4_latency", 32'(last_lat), 32'd50);
    snap = srl_rises;
    repeat (100) @(negedge clk);
    n = 0;
    while (m_frame != 30 && n < 70) begin @(negedge clk); n++; end
    check("t4_no_poll", 32'(srl_rises), 32'(snap));
    en = 1'b1;
    wait_srl("t4b", 80);
    check("t4_start_at_wrap", 32'(m_frame), 32'd1);

    // 5: reset during LOW(3)
    n = 0;
    while (m_k != 25 && n < 60) begin @(negedge clk); n++; end
    rst_b = 1'b0;
    @(negedge clk);
    check("t5_srl",     32'(srl),     32'h0);
    check("t5_srclk",   32'(srclk),   32'h0);
    check("t5_buttons", 32'(buttons), 32'h0);
    rst_b = 1'b1;
    snap = 0;
    repeat (30) begin @(negedge clk); if (valid) snap++; end
    check("t5_no_valid", 32'(snap), 32'd0);
    wait_valid("t5", 100);
    check("t5_buttons_after", 32'(buttons), 32'h3CA7);
    check("t5_pressed_after", 32'(pressed), 32'h3CA7);

    // 6: 16-bit instance
    n = 0;
    do begin @(negedge clk); n++; end while (!valid16 && n < 300);
    check("t6_valid_seen", 32'(valid16), 32'd1);
    check("t6_buttons", 32'(buttons16), 32'h8001);
    check("t6_pulses",  32'(last_pulses16), 32'd15);
    check("t6_latency", 32'(lat16), 32'd98);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
